// File: rtl/burst_ram.sv
// burst_ram: single-port synchronous RAM on a shared tri-state data bus.
// Supports auto-incrementing read/write bursts of len+1 beats, a busy/rvalid
// handshake and a one-cycle err pulse on a command with both rd and wd set.
// All outputs are registered; the memory is cleared by the asynchronous reset.
module burst_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned LEN_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              rd,
    input  logic              wd,
    input  logic [ADDR_W-1:0] addlines,
    input  logic [LEN_W-1:0]  len,
    inout  wire  [DATA_W-1:0] datalines,
    output logic              busy,
    output logic              rvalid,
    output logic              err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    // Registered state
    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;     // address of the next beat
    logic [LEN_W-1:0]    r_cnt;      // beats still to come after the current one
    logic [DATA_W-1:0]   r_dout;     // read output latch
    logic                r_oe;       // bus driver enable
    logic                r_err;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    // Next-state / control from the FSM decode
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [LEN_W-1:0]    w_cnt_nxt;
    logic                w_oe_nxt;
    logic                w_err_nxt;
    logic                w_we;
    logic [ADDR_W-1:0]   w_waddr;
    logic                w_rd_en;
    logic [ADDR_W-1:0]   w_raddr;
    logic [DATA_W-1:0]   w_din;

    // The bus is only ever driven while a read beat is presented.
    assign datalines = r_oe ? r_dout : {DATA_W{1'bz}};
    assign w_din     = datalines;

    assign busy   = (r_state != IDLE);
    assign rvalid = r_oe;
    assign err    = r_err;

    // State register and burst bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_oe    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_oe    <= w_oe_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Command decode, burst sequencing and memory port control
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_cnt_nxt   = r_cnt;
        w_oe_nxt    = 1'b0;
        w_err_nxt   = 1'b0;
        w_we        = 1'b0;
        w_waddr     = r_addr;
        w_rd_en     = 1'b0;
        w_raddr     = r_addr;
        case (r_state)
            IDLE: begin
                if (cs) begin
                    if (rd && wd) begin
                        w_err_nxt = 1'b1;
                    end else if (wd) begin
                        // Beat 0 is written on the accept edge itself.
                        w_we       = 1'b1;
                        w_waddr    = addlines;
                        w_addr_nxt = addlines + ADDR_W'(1);
                        w_cnt_nxt  = len;
                        if (len != '0) begin
                            w_state_nxt = WRITE;
                        end
                    end else if (rd) begin
                        w_rd_en     = 1'b1;
                        w_raddr     = addlines;
                        w_addr_nxt  = addlines + ADDR_W'(1);
                        w_cnt_nxt   = len;
                        w_oe_nxt    = 1'b1;
                        w_state_nxt = READ;
                    end
                end
            end
            WRITE: begin
                if (!cs) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_we       = 1'b1;
                    w_waddr    = r_addr;
                    w_addr_nxt = r_addr + ADDR_W'(1);
                    w_cnt_nxt  = r_cnt - LEN_W'(1);
                    if (r_cnt == LEN_W'(1)) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            READ: begin
                // The last beat stays on the bus for one cycle, then release.
                if (!cs || (r_cnt == '0)) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_rd_en    = 1'b1;
                    w_raddr    = r_addr;
                    w_addr_nxt = r_addr + ADDR_W'(1);
                    w_cnt_nxt  = r_cnt - LEN_W'(1);
                    w_oe_nxt   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Read output latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout <= '0;
        end else if (w_rd_en) begin
            r_dout <= r_mem[w_raddr];
        end
    end

    // Memory words, one register per word so reset can clear every entry
    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_mem[g] <= '0;
            end else if (w_we && (w_waddr == ADDR_W'(g))) begin
                r_mem[g] <= w_din;
            end
        end
    end

endmodule

// File: tb/tb_burst_ram.sv
// Scoreboard bench for burst_ram: stimulus pushes expected read beats and
// expected err pulses; a negedge monitor pops and compares them.
module tb_burst_ram;

    localparam int DW = 8;
    localparam int AW = 5;
    localparam int LW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          cs, rd, wd;
    logic [AW-1:0] addlines;
    logic [LW-1:0] len;
    wire  [DW-1:0] datalines;
    logic [DW-1:0] tb_dq;
    logic          tb_dq_en;
    logic          busy, rvalid, err;

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0] sb_q[$];
    int            err_q[$];

    assign datalines = tb_dq_en ? tb_dq : {DW{1'bz}};

    always #5 clk = ~clk;

    burst_ram #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst), .cs(cs), .rd(rd), .wd(wd),
        .addlines(addlines), .len(len), .datalines(datalines),
        .busy(busy), .rvalid(rvalid), .err(err)
    );

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    task automatic edge_();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cs = 1'b0; rd = 1'b0; wd = 1'b0; tb_dq_en = 1'b0;
    endtask

    // Drives 'beats' beats; if fewer than len+1, cs is dropped on the next edge.
    task automatic write_burst(input logic [AW-1:0] a, input logic [LW-1:0] l,
                               input logic [DW-1:0] d[$], input int beats);
        cs = 1'b1; wd = 1'b1; rd = 1'b0; addlines = a; len = l;
        tb_dq_en = 1'b1; tb_dq = d[0];
        edge_();
        check("wr_busy_accept", busy, (l != 0) ? 1 : 0);
        wd = 1'b0; addlines = ~a; len = ~l;
        for (int k = 1; k < beats; k++) begin
            tb_dq = d[k];
            edge_();
            check("wr_busy_beat", busy, (k < int'(l)) ? 1 : 0);
        end
        if (beats < int'(l) + 1) begin
            cs = 1'b0; tb_dq_en = 1'b0;
            edge_();
            check("wr_busy_abort", busy, 0);
        end
    endtask

    task automatic read_burst(input logic [AW-1:0] a, input logic [LW-1:0] l,
                              input logic [DW-1:0] e[$], input int beats, input bit noise);
        for (int k = 0; k < beats; k++) sb_q.push_back(e[k]);
        cs = 1'b1; rd = 1'b1; wd = 1'b0; addlines = a; len = l; tb_dq_en = 1'b0;
        edge_();
        check("rd_busy_accept", busy, 1);
        rd = 1'b0;
        for (int k = 1; k < beats; k++) begin
            if (noise) begin
                rd = (k % 2 == 1);
                addlines = ~a;
            end
            edge_();
            check("rd_busy_beat", busy, 1);
        end
        rd = 1'b0;
        if (beats < int'(l) + 1) cs = 1'b0;
        edge_();
        check("rd_busy_end", busy, 0);
        check("rd_rvalid_end", rvalid, 0);
        idle();
    endtask

    // Monitor: compares every presented read beat and err pulse
    initial begin
        forever begin
            @(negedge clk);
            if (rvalid) begin
                if (sb_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL rdata_unexpected: got %0h expected no beat at %0t", datalines, $time);
                end else begin
                    check("rdata", datalines, sb_q.pop_front());
                end
            end
            if (err) begin
                if (err_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL err_unexpected: got 1 expected 0 at %0t", $time);
                end else begin
                    check("err_pulse", err, err_q.pop_front());
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; idle(); addlines = '0; len = '0; tb_dq = '0;
        edge_(); edge_();
        check("reset_busy", busy, 0);
        check("reset_rvalid", rvalid, 0);
        check("reset_err", err, 0);
        rst = 1'b0;

        // Single-word write then read
        write_burst(5'd20, 3'd0, '{8'd69}, 1);
        idle();
        read_burst(5'd20, 3'd0, '{8'd69}, 1, 1'b0);

        // Wrapping write burst, back-to-back single write, read back
        write_burst(5'd30, 3'd3, '{8'd1, 8'd2, 8'd3, 8'd4}, 4);
        write_burst(5'd10, 3'd0, '{8'h55}, 1);
        idle();
        read_burst(5'd30, 3'd3, '{8'd1, 8'd2, 8'd3, 8'd4}, 4, 1'b0);
        read_burst(5'd10, 3'd0, '{8'h55}, 1, 1'b0);

        // Illegal command held for two edges
        cs = 1'b1; rd = 1'b1; wd = 1'b1; addlines = 5'd30; len = 3'd0;
        tb_dq_en = 1'b1; tb_dq = 8'hEE;
        err_q.push_back(1); err_q.push_back(1);
        edge_();
        check("illegal_busy", busy, 0);
        check("illegal_rvalid", rvalid, 0);
        edge_();
        check("illegal_err_repeat", err, 1);
        idle();
        edge_();
        check("illegal_err_clear", err, 0);
        read_burst(5'd30, 3'd0, '{8'd1}, 1, 1'b0);

        // Aborted read after beat 2, aborted write after beat 1
        read_burst(5'd0, 3'd7, '{8'd3, 8'd4, 8'd0}, 3, 1'b0);
        write_burst(5'd5, 3'd3, '{8'hA1, 8'hA2, 8'hA3, 8'hA4}, 2);
        idle();
        read_burst(5'd5, 3'd3, '{8'hA1, 8'hA2, 8'h00, 8'h00}, 4, 1'b0);

        // Reset in the middle of a read burst
        sb_q.push_back(8'd1); sb_q.push_back(8'd2);
        cs = 1'b1; rd = 1'b1; addlines = 5'd30; len = 3'd3;
        edge_();
        rd = 1'b0;
        edge_();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_rvalid", rvalid, 0);
        check("midrst_busy", busy, 0);
        idle();
        edge_(); edge_();
        rst = 1'b0;
        read_burst(5'd30, 3'd0, '{8'd0}, 1, 1'b0);
        read_burst(5'd20, 3'd0, '{8'd0}, 1, 1'b0);
        read_burst(5'd1, 3'd0, '{8'd0}, 1, 1'b0);

        // rd pulses during a read burst are ignored
        write_burst(5'd12, 3'd2, '{8'd7, 8'd8, 8'd9}, 3);
        idle();
        read_burst(5'd12, 3'd2, '{8'd7, 8'd8, 8'd9}, 3, 1'b1);

        edge_(); edge_(); edge_();
        check("sb_drained", sb_q.size(), 0);
        check("err_q_drained", err_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
